fir_sm_fifo: RTL and testbench
==============================

// Module: fir_sm_fifo
// PURPOSE
//  Output buffer directly downstream of the FIR AXI-Stream master (sm_*). Holds up to pDEPTH results
//  so consumer back-pressure does not stall the FIR, and forwards them to the consumer with tlast.
//  Exposes per-frame statistics (delivered count, peak |y|, frame_done, level) on a read-only AXI-Lite slave.
// PARAMETERS
//  pADDR_WIDTH  12  AXI-Lite address width
//  pDATA_WIDTH  32  sample/register width; samples are signed
//  pDEPTH       8   FIFO entries; power of two, >=2
// PORTS
//  axis_clk    in   1     single clock for all logic
//  axis_rst_n  in   1     asynchronous active-low reset
//  s_tvalid    in   1     from FIR sm_tvalid
//  s_tdata     in   32    from FIR sm_tdata
//  s_tlast     in   1     from FIR sm_tlast
//  s_tready    out  1     to FIR sm_tready
//  m_tvalid    out  1     to consumer
//  m_tdata     out  32    to consumer
//  m_tlast     out  1     to consumer
//  m_tready    in   1     from consumer
//  arvalid     in   1     AXI-Lite read address valid
//  araddr      in   12    AXI-Lite read address
//  arready     out  1     AXI-Lite read address ready
//  rvalid      out  1     AXI-Lite read data valid
//  rdata       out  32    AXI-Lite read data
//  rready      in   1     AXI-Lite read data ready
// BEHAVIOUR
//  Reset: s_tready=0 during reset, 1 the first cycle after release. m_tvalid=0, m_tdata=0, m_tlast=0.
//   arready=0 during reset, 1 after release. rvalid=0, rdata=0. FIFO is empty; all statistics are 0.
//  Push: s_tvalid&s_tready stores {tlast,tdata}. s_tready = !full, registered. No combinational path from m_tready.
//   When full, a simultaneous pop does not allow a push in the same cycle.
//  Pop: m_tvalid = !empty. m_tdata/m_tlast present the head entry. Handshake m_tvalid&m_tready advances rd_ptr.
//   Head data is stable while m_tvalid & !m_tready.
//  Latency: a sample pushed in cycle N is on m_* in cycle N+1 when the FIFO was empty. Sustained 1 sample/clk.
//  Pointers: log2(pDEPTH)+1 bits, wrap modulo 2*pDEPTH. full = MSBs differ & low bits equal. empty = pointers equal.
//  Simultaneous push+pop, not full: level is unchanged and both pointers advance.
//  Statistics are updated on pop, i.e. on delivered samples:
//   - sample_cnt: +1 per pop, 32-bit, wraps.
//   - peak: max |y|. |y| is the two's-complement negate for negative y; -2^31 saturates to 0x7FFF_FFFF.
//   - frame_done: set on the pop carrying tlast=1.
//   - Frame restart: the first pop after frame_done clears frame_done and loads sample_cnt=1 and peak=|y|.
//   - A tlast=1 sample with frame_done already set behaves the same: restart, then set frame_done again.
//  AXI-Lite read:
//   - arready = !rvalid. On arvalid&arready, the next cycle drives rvalid=1 and rdata=reg[araddr].
//   - rvalid and rdata hold until rready. rvalid then drops, and arready returns 1 the following cycle.
//   - Register map:
//     0x00 {28'b0, full, empty, 1'b0, frame_done}
//     0x04 sample_cnt
//     0x08 peak
//     0x0C level (0..pDEPTH)
//     any other address -> 0
//   - Register snapshot is taken at the ar handshake. Reads have no side effects.
// STRUCTURE
//  Shared package fir_pkg: pDATA_WIDTH, STAT_ADDR_STATUS/CNT/PEAK/LEVEL constants, status bit indices.
//  One sub-module, fir_sync_fifo, holds storage, pointers, full/empty and level.
//  Statistics and the AXI-Lite slave live in the top.
// TESTING
//  - Push 0..9 with m_tready=1, tlast on 9: out 0..9 in order, 1/clk, 1-cycle latency.
//    Read 0x04=10, 0x00 bit0=1.
//  - m_tready=0, push until s_tready=0: exactly 8 accepted, 0x0C=8, 0x00=0x8.
//    Raise m_tready: 8 out in order, then 0x00=0x4 (empty).
//  - Full FIFO with s_tvalid&m_tready held: no push in the pop cycle. Next cycle s_tready=1. No loss or duplication.
//  - Samples {5,-40,0x8000_0000,7} with tlast on 7: 0x08=0x7FFF_FFFF.
//    Next frame {3} with tlast: 0x04=1, 0x08=3.
//  - Assert axis_rst_n low mid-frame with 4 entries held: all outputs to reset values immediately.
//    After release: empty, stats 0, s_tready=1.
//  - Read 0x10 -> 0. Hold rready=0 for 5 cycles: rvalid/rdata stable, arready=0 throughout.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR output buffer: data width, statistics register map, status bit positions.
package fir_pkg;

    localparam int pDATA_WIDTH = 32;

    localparam logic [11:0] STAT_ADDR_STATUS = 12'h000;
    localparam logic [11:0] STAT_ADDR_CNT    = 12'h004;
    localparam logic [11:0] STAT_ADDR_PEAK   = 12'h008;
    localparam logic [11:0] STAT_ADDR_LEVEL  = 12'h00C;

    localparam int STAT_BIT_DONE  = 0;
    localparam int STAT_BIT_EMPTY = 2;
    localparam int STAT_BIT_FULL  = 3;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO: storage, extra-MSB pointers, full/empty, level and next-cycle full flag.
module fir_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       full_nxt,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             push_ok, pop_ok;

    // Guard against overflow/underflow regardless of what the caller does.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer state after this edge; lets the caller register a ready that is exact next cycle.
    always_comb begin
        wr_nxt   = wr_ptr + (AW+1)'(push_ok);
        rd_nxt   = rd_ptr + (AW+1)'(pop_ok);
        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fir_sm_fifo.sv
// FIR stream output buffer with per-frame delivery statistics on a read-only AXI-Lite slave.
module fir_sm_fifo #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   rready
);
    import fir_pkg::*;

    localparam int AW = $clog2(pDEPTH);

    logic                   push, pop, full, full_nxt, empty;
    logic [pDATA_WIDTH:0]   head;
    logic [AW:0]            level;
    logic [pDATA_WIDTH-1:0] y_abs, sample_cnt, peak, reg_mux;
    logic                   frame_done, ar_hs, r_hs, rvalid_nxt;

    assign push = s_tvalid & s_tready;
    assign pop  = m_tvalid & m_tready;

    fir_sync_fifo #(.WIDTH(pDATA_WIDTH + 1), .DEPTH(pDEPTH)) u_fifo (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .push     (push),
        .wdata    ({s_tlast, s_tdata}),
        .pop      (pop),
        .rdata    (head),
        .full     (full),
        .full_nxt (full_nxt),
        .empty    (empty),
        .level    (level)
    );

    // Head is masked while empty so stale storage never shows on m_*.
    assign m_tvalid = ~empty;
    assign m_tdata  = empty ? '0 : head[pDATA_WIDTH-1:0];
    assign m_tlast  = ~empty & head[pDATA_WIDTH];

    // Upstream ready from the post-edge full flag: no path from m_tready, yet no bubble after a pop.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) s_tready <= 1'b0;
        else             s_tready <= ~full_nxt;
    end

    // Magnitude of the head sample; the most negative value saturates to the most positive.
    always_comb begin
        y_abs = m_tdata;
        if (m_tdata[pDATA_WIDTH-1]) begin
            if (m_tdata == {1'b1, {(pDATA_WIDTH-1){1'b0}}}) y_abs = {1'b0, {(pDATA_WIDTH-1){1'b1}}};
            else                                           y_abs = -m_tdata;
        end
    end

    // Frame statistics on delivered samples; the pop after frame_done starts a new frame.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            sample_cnt <= '0;
            peak       <= '0;
            frame_done <= 1'b0;
        end else if (pop) begin
            frame_done <= m_tlast;
            if (frame_done) begin
                sample_cnt <= pDATA_WIDTH'(1);
                peak       <= y_abs;
            end else begin
                sample_cnt <= sample_cnt + pDATA_WIDTH'(1);
                if (y_abs > peak) peak <= y_abs;
            end
        end
    end

    // Register map decode, sampled at the address handshake.
    always_comb begin
        reg_mux = '0;
        case (araddr)
            pADDR_WIDTH'(STAT_ADDR_STATUS): begin
                reg_mux[STAT_BIT_FULL]  = full;
                reg_mux[STAT_BIT_EMPTY] = empty;
                reg_mux[STAT_BIT_DONE]  = frame_done;
            end
            pADDR_WIDTH'(STAT_ADDR_CNT):   reg_mux = sample_cnt;
            pADDR_WIDTH'(STAT_ADDR_PEAK):  reg_mux = peak;
            pADDR_WIDTH'(STAT_ADDR_LEVEL): reg_mux = pDATA_WIDTH'(level);
            default:                       reg_mux = '0;
        endcase
    end

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    // One outstanding read: rvalid set by ar handshake, cleared by r handshake.
    always_comb begin
        rvalid_nxt = rvalid;
        if (r_hs)  rvalid_nxt = 1'b0;
        if (ar_hs) rvalid_nxt = 1'b1;
    end

    // Read channel registers; arready tracks the complement of the next rvalid.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= ~rvalid_nxt;
            rvalid  <= rvalid_nxt;
            if (ar_hs)     rdata <= reg_mux;
            else if (r_hs) rdata <= '0;
        end
    end

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Directed bench for fir_sm_fifo: streaming table, fill/drain, full-boundary, stats, reset and read hold.
module tb_fir_sm_fifo;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tready, m_tvalid, m_tlast, arready, rvalid;
    logic [31:0] m_tdata, rdata;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [11:0] araddr = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic        exp_mv;
        logic [31:0] exp_md;
        logic        exp_ml;
        logic        exp_sr;
    } vec_t;

    vec_t vecs [11];

    always #5 axis_clk = ~axis_clk;

    fir_sm_fifo dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .arready    (arready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rready     (rready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_reset();
        s_tvalid = 0; s_tlast = 0; m_tready = 0; arvalid = 0; rready = 0;
        axis_rst_n = 0;
        repeat (2) @(posedge axis_clk);
        #1 axis_rst_n = 1;
        tick();
    endtask

    // Read one register, optionally holding rready low for 'hold' cycles.
    task automatic rd(input logic [11:0] a, input int hold, input logic [31:0] exp, input string nm);
        int n = 0;
        tick();
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) begin
            chk({nm, "_arready_timeout"}, 32'(arready), 32'd1);
            return;
        end
        arvalid = 1; araddr = a;
        tick();
        arvalid = 0;
        chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
        chk(nm, rdata, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({nm, "_hold_rvalid"}, 32'(rvalid), 32'd1);
            chk({nm, "_hold_rdata"}, rdata, exp);
            chk({nm, "_hold_arready"}, 32'(arready), 32'd0);
        end
        rready = 1;
        tick();
        rready = 0;
        chk({nm, "_rvalid_drop"}, 32'(rvalid), 32'd0);
        chk({nm, "_arready_back"}, 32'(arready), 32'd1);
    endtask

    task automatic push1(input logic [31:0] d, input logic l);
        s_tvalid = 1; s_tdata = d; s_tlast = l;
        chk("push_s_tready", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 0; s_tlast = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;

        // Streaming table: push 0..9 (tlast on 9) with the consumer always ready.
        for (int i = 0; i < 11; i++) begin
            vecs[i].sv     = (i < 10);
            vecs[i].sd     = (i < 10) ? 32'(i) : 32'd0;
            vecs[i].sl     = (i == 9);
            vecs[i].mr     = 1'b1;
            vecs[i].exp_mv = (i > 0);
            vecs[i].exp_md = (i > 0) ? 32'(i - 1) : 32'd0;
            vecs[i].exp_ml = (i == 10);
            vecs[i].exp_sr = 1'b1;
        end

        // Values while reset is held.
        #12;
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        do_reset();
        chk("post_rst_s_tready", 32'(s_tready), 32'd1);
        chk("post_rst_arready", 32'(arready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            s_tvalid = vecs[i].sv; s_tdata = vecs[i].sd; s_tlast = vecs[i].sl; m_tready = vecs[i].mr;
            chk($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_mv));
            chk($sformatf("vec%0d_m_tdata", i), m_tdata, vecs[i].exp_md);
            chk($sformatf("vec%0d_m_tlast", i), 32'(m_tlast), 32'(vecs[i].exp_ml));
            chk($sformatf("vec%0d_s_tready", i), 32'(s_tready), 32'(vecs[i].exp_sr));
            tick();
        end
        s_tvalid = 0; s_tlast = 0;
        rd(12'h004, 0, 32'd10, "t1_cnt");
        rd(12'h000, 0, 32'h5, "t1_status");

        // Fill with the consumer stalled: exactly pDEPTH accepted.
        do_reset();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            s_tvalid = 1; s_tdata = 32'(100 + acc);
            if (s_tready) acc++;
            tick();
        end
        s_tvalid = 0;
        chk("t2_accepted", 32'(acc), 32'd8);
        chk("t2_s_tready_full", 32'(s_tready), 32'd0);
        rd(12'h00C, 0, 32'd8, "t2_level");
        rd(12'h000, 0, 32'h8, "t2_status");

        // Full boundary: pop while offering a push; the push must wait one cycle.
        m_tready = 1; s_tvalid = 1; s_tdata = 32'd200;
        chk("t3_no_push_when_full", 32'(s_tready), 32'd0);
        chk("t3_head0", m_tdata, 32'd100);
        tick();
        chk("t3_s_tready_after_pop", 32'(s_tready), 32'd1);
        chk("t3_head1", m_tdata, 32'd101);
        tick();
        s_tvalid = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t3_drain%0d_valid", i), 32'(m_tvalid), 32'd1);
            chk($sformatf("t3_drain%0d", i), m_tdata, (i < 6) ? 32'(102 + i) : 32'd200);
            tick();
        end
        chk("t3_empty_valid", 32'(m_tvalid), 32'd0);
        m_tready = 0;
        rd(12'h000, 0, 32'h4, "t3_status");
        rd(12'h004, 0, 32'd9, "t3_cnt");

        // Peak with the most-negative sample saturating, then a one-sample frame.
        do_reset();
        m_tready = 1;
        push1(32'd5, 0);
        push1(32'hFFFF_FFD8, 0);
        push1(32'h8000_0000, 0);
        push1(32'd7, 1);
        rd(12'h008, 3, 32'h7FFF_FFFF, "t4_peak");
        rd(12'h004, 0, 32'd4, "t4_cnt");
        rd(12'h000, 0, 32'h5, "t4_status");
        push1(32'd3, 1);
        rd(12'h004, 0, 32'd1, "t4_cnt2");
        rd(12'h008, 0, 32'd3, "t4_peak2");
        rd(12'h000, 0, 32'h5, "t4_status2");

        // Reset mid-frame with 4 entries held.
        m_tready = 0;
        for (int i = 1; i <= 4; i++) push1(32'(i), 0);
        chk("t5_m_tvalid_held", 32'(m_tvalid), 32'd1);
        #3 axis_rst_n = 0;
        #1;
        chk("t5_rst_s_tready", 32'(s_tready), 32'd0);
        chk("t5_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_m_tdata", m_tdata, 32'd0);
        chk("t5_rst_arready", 32'(arready), 32'd0);
        @(posedge axis_clk);
        #1 axis_rst_n = 1;
        tick();
        chk("t5_s_tready", 32'(s_tready), 32'd1);
        chk("t5_empty", 32'(m_tvalid), 32'd0);
        rd(12'h000, 0, 32'h4, "t5_status");
        rd(12'h004, 0, 32'd0, "t5_cnt");
        rd(12'h008, 0, 32'd0, "t5_peak");
        rd(12'h00C, 0, 32'd0, "t5_level");

        // Unmapped address with rready held low.
        rd(12'h010, 5, 32'd0, "t6_unmapped");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
